l0_skew_fifo_bank: RTL and testbench
====================================

// Module: l0_skew_fifo_bank
// PURPOSE
//  Parametrised L0 input buffer feeding the systolic array's row inputs: `col` lanes of
//  `depth`-entry circular FIFOs, written in parallel with one wide word per cycle.
//  The read strobe either ripples one lane per cycle (diagonal/skewed feed) or hits all
//  lanes together (broadcast feed). Per-lane valid flags are added.
//  Output data is registered. Self-contained storage; no FIFO submodule.
// PARAMETERS
//  col    8  number of lanes (FIFOs); >=2
//  bw     4  bits per lane entry
//  depth  8  entries per lane; power of 2, >=2; pointers are log2(depth) bits, count log2(depth)+1
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       asynchronous, active-low; clears all state
//  wr       in   1       write request; pushes in[] into every lane
//  rd       in   1       read request; injects a read token into the lane strobe chain
//  mode     in   1       0 = skewed (lane i reads i cycles after lane 0), 1 = broadcast
//  in       in   bw*col  lane i data = in[bw*(i+1)-1 : bw*i]
//  out      out  bw*col  registered lane data, same slicing as in
//  o_valid  out  col     o_valid[i] high for one cycle when out lane i was updated
//  o_full   out  1       any lane count == depth
//  o_ready  out  1       ~o_full
//  o_empty  out  1       all lane counts == 0
// BEHAVIOUR
//  Reset (reset==0, asynchronous): pointers, counts, strobe chain = 0; out = 0; o_valid = 0;
//   o_full = 0, o_ready = 1, o_empty = 1. Deassertion is synchronised by the system; no internal sync.
//  Write: at a clk edge with wr==1 and o_full==0, every lane stores its slice at wptr, wptr+1 (mod depth),
//   count+1. With wr==1 and o_full==1 the write is dropped for ALL lanes (no partial writes).
//  Strobe chain rd_sr[col-1:0], updated every edge:
//   rd_sr <= (rd_sr << 1) | (mode ? {col{rd}} : {{col-1{1'b0}},rd}).
//   mode is evaluated at injection only; tokens already in flight keep shifting, so a mode change
//   mid-flight is legal and deterministic (OR-merge of tokens).
//  Lane read: at the edge where rd_sr[i]==1 and count[i]!=0: out lane i <= mem[i][rptr], rptr+1 (mod depth),
//   count-1, o_valid[i] <= 1. If rd_sr[i]==1 and the lane is empty: no pointer move, out lane holds,
//   o_valid[i] <= 0 (underflow is silent). If rd_sr[i]==0: o_valid[i] <= 0, out lane holds.
//  Latency (rd sampled at edge E0): skewed: lane i out/o_valid valid after edge E0+1+i;
//   broadcast: all lanes after E0+1. Back-to-back rd every cycle sustains 1 entry/lane/cycle.
//  Simultaneous write and read on one lane in one edge: both happen, count unchanged. A write is
//   still dropped if o_full was 1 before that edge, even if a read frees space in the same edge.
//  Flags are combinational from registered counts (no extra latency): o_full at count==depth.
//  Lanes can diverge in count in skewed mode; o_full/o_empty reduce across all lanes.
//  Wrap-around: pointers wrap depth-1 -> 0 naturally; count distinguishes full from empty.
// CONFIGURATION
//  L0_DROP_CNT_EN defined: extra output o_drop_cnt [7:0]. It increments on every dropped write
//   (wr & o_full) and on every empty-lane read event (one per lane per edge). It saturates at 255
//   and clears only on reset.
//  Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING  (col=8, bw=4, depth=8)
//  1 Reset: hold reset=0 mid-stream -> out=0, o_valid=0, o_empty=1, o_ready=1 immediately (async).
//  2 Skewed: write 0x76543210, 0xFEDCBA98; rd=1 two cycles, mode=0 -> o_valid=8'h01,8'h03,8'h06,8'h0C..8'h80;
//    lane i shows i then i+8 in consecutive cycles.
//  3 Broadcast: same writes, mode=1, rd one cycle -> after 1 edge o_valid=8'hFF, out=0x76543210.
//  4 Full: 8 writes -> o_full=1; 9th write 0xAAAAAAAA dropped; drain 8 -> 9th value never seen.
//    With L0_DROP_CNT_EN, o_drop_cnt=1.
//  5 Wrap and concurrency: write 12 values with skewed reads interleaved, wr&rd on same edges.
//    Data order is preserved across pointer wrap; counts never exceed 8.
//  6 Underflow and mode switch: rd on an empty bank -> o_valid stays 0, pointers unchanged.
//    Switch mode 0->1 while tokens are in flight: in-flight lanes still fire on their scheduled cycles.

Source files
------------

// File: rtl/l0_skew_fifo_bank.sv
// L0 input buffer: col lanes of depth-entry FIFOs, parallel write, skewed or broadcast read strobe.
// Optional `L0_DROP_CNT_EN adds o_drop_cnt, a saturating count of dropped writes and empty-lane reads.
module l0_skew_fifo_bank #(
    parameter int unsigned col   = 8,
    parameter int unsigned bw    = 4,
    parameter int unsigned depth = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic              mode,
    input  logic [bw*col-1:0] in,
    output logic [bw*col-1:0] out,
    output logic [col-1:0]    o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty
`ifdef L0_DROP_CNT_EN
    ,
    output logic [7:0]        o_drop_cnt
`endif
);
    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = PW + 1;

    logic [bw-1:0]     mem_q   [col][depth];
    logic [bw-1:0]     mem_d   [col][depth];
    logic [PW-1:0]     rptr_q  [col];
    logic [PW-1:0]     rptr_d  [col];
    logic [CW-1:0]     count_q [col];
    logic [CW-1:0]     count_d [col];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [col-1:0]    rd_sr_q, rd_sr_d;
    logic [bw*col-1:0] out_q, out_d;
    logic [col-1:0]    valid_q, valid_d;
    logic [col-1:0]    lane_rd;
    logic              wr_en;

    // Flags reduce the registered lane counts with no added latency.
    always_comb begin
        o_full  = 1'b0;
        o_empty = 1'b1;
        for (int i = 0; i < int'(col); i++) begin
            if (count_q[i] == CW'(depth)) o_full = 1'b1;
            if (count_q[i] != '0)         o_empty = 1'b0;
        end
    end

    assign o_ready = ~o_full;
    assign out     = out_q;
    assign o_valid = valid_q;

    always_comb begin
        wr_en   = wr & ~o_full;
        mem_d   = mem_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        out_d   = out_q;
        valid_d = '0;
        lane_rd = '0;
        wptr_d  = wr_en ? wptr_q + PW'(1) : wptr_q;
        // Broadcast injects a token into every stage; all tokens keep shifting afterwards.
        rd_sr_d = (rd_sr_q << 1) | (mode ? {col{rd}} : {{(col-1){1'b0}}, rd});
        for (int i = 0; i < int'(col); i++) begin
            lane_rd[i] = rd_sr_q[i] && (count_q[i] != '0);
            if (wr_en) mem_d[i][wptr_q] = in[bw*i +: bw];
            if (lane_rd[i]) begin
                out_d[bw*i +: bw] = mem_q[i][rptr_q[i]];
                rptr_d[i]         = rptr_q[i] + PW'(1);
                valid_d[i]        = 1'b1;
            end
            count_d[i] = count_q[i] + CW'(wr_en) - CW'(lane_rd[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rd_sr_q <= '0;
            out_q   <= '0;
            valid_q <= '0;
            for (int i = 0; i < int'(col); i++) begin
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rd_sr_q <= rd_sr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is only observable after a write, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef L0_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [9:0] drop_sum;

    always_comb begin
        drop_sum = 10'(drop_cnt_q) + 10'(wr & o_full);
        for (int i = 0; i < int'(col); i++) begin
            drop_sum = drop_sum + 10'(rd_sr_q[i] && (count_q[i] == '0));
        end
        drop_cnt_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_l0_skew_fifo_bank.sv
// Self-checking bench for l0_skew_fifo_bank: directed vector tables, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_l0_skew_fifo_bank;
    localparam int unsigned COL   = 8;
    localparam int unsigned BW    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = COL * BW;

    logic           clk = 1'b0;
    logic           reset, wr, rd, mode;
    logic [W-1:0]   in_w, out_w;
    logic [COL-1:0] o_valid;
    logic           o_full, o_ready, o_empty;
`ifdef L0_DROP_CNT_EN
    logic [7:0]     o_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l0_skew_fifo_bank #(.col(COL), .bw(BW), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .mode(mode), .in(in_w),
        .out(out_w), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_empty(o_empty)
`ifdef L0_DROP_CNT_EN
        , .o_drop_cnt(o_drop_cnt)
`endif
    );

    // Reference model: per-lane queues plus a list of read requests and the edges they reach.
    typedef struct { int unsigned at; bit bcast; } rd_req_t;
    int unsigned    lane_q [COL][$];
    rd_req_t        reqs[$];
    int unsigned    edge_n = 0;
    logic [W-1:0]   m_out;
    logic [COL-1:0] m_valid;
    int unsigned    m_drop;

    function automatic void model_clear();
        for (int i = 0; i < int'(COL); i++) lane_q[i].delete();
        reqs.delete();
        m_out   = '0;
        m_valid = '0;
        m_drop  = 0;
    endfunction

    // A skewed request at edge E reads lane i at E+1+i; a broadcast one reads lane i at E+1..E+1+i.
    task automatic model_edge();
        bit full = 1'b0;
        for (int i = 0; i < int'(COL); i++) if (lane_q[i].size() == int'(DEPTH)) full = 1'b1;
        m_valid = '0;
        for (int i = 0; i < int'(COL); i++) begin
            bit fire = 1'b0;
            foreach (reqs[k]) begin
                if (!reqs[k].bcast && edge_n == reqs[k].at + 1 + i) fire = 1'b1;
                if (reqs[k].bcast && edge_n >= reqs[k].at + 1 && edge_n <= reqs[k].at + 1 + i) fire = 1'b1;
            end
            if (fire) begin
                if (lane_q[i].size() != 0) begin
                    m_out[i*BW +: BW] = BW'(lane_q[i].pop_front());
                    m_valid[i] = 1'b1;
                end else begin
                    m_drop++;
                end
            end
        end
        if (wr) begin
            if (full) m_drop++;
            else for (int i = 0; i < int'(COL); i++) lane_q[i].push_back(int'(in_w[i*BW +: BW]));
        end
        if (m_drop > 255) m_drop = 255;
        if (rd) reqs.push_back('{edge_n, mode});
        while (reqs.size() != 0 && reqs[0].at + COL < edge_n) void'(reqs.pop_front());
        edge_n++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic check_model(string tag);
        bit mf = 1'b0;
        bit me = 1'b1;
        for (int i = 0; i < int'(COL); i++) begin
            if (lane_q[i].size() == int'(DEPTH)) mf = 1'b1;
            if (lane_q[i].size() != 0) me = 1'b0;
        end
        chk({tag, ".out"},   out_w,        m_out);
        chk({tag, ".valid"}, W'(o_valid),  W'(m_valid));
        chk({tag, ".full"},  W'(o_full),   W'(mf));
        chk({tag, ".ready"}, W'(o_ready),  W'(!mf));
        chk({tag, ".empty"}, W'(o_empty),  W'(me));
`ifdef L0_DROP_CNT_EN
        chk({tag, ".drop"},  W'(o_drop_cnt), W'(m_drop));
`endif
    endtask

    task automatic do_reset();
        wr   = 1'b0;
        rd   = 1'b0;
        mode = 1'b0;
        in_w = '0;
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    typedef struct {
        bit         pre_rst;
        logic       wr, rd, mode;
        logic [31:0] din;
        logic [7:0]  ev;
        logic [31:0] eout;
        logic        ef, ee;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit pr, logic w, logic r, logic m, logic [31:0] d,
                                logic [7:0] ev, logic [31:0] eo, logic ef, logic ee);
        vec_t v;
        v.pre_rst = pr; v.wr = w; v.rd = r; v.mode = m; v.din = d;
        v.ev = ev; v.eout = eo; v.ef = ef; v.ee = ee;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        bit seen_a;

        // Skewed read of two words, then a broadcast read with trailing tokens.
        add(1, 1, 0, 0, 32'h76543210, 8'h00, 32'h00000000, 0, 0);
        add(0, 1, 0, 0, 32'hFEDCBA98, 8'h00, 32'h00000000, 0, 0);
        add(0, 0, 1, 0, 32'h0,        8'h00, 32'h00000000, 0, 0);
        add(0, 0, 1, 0, 32'h0,        8'h01, 32'h00000000, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h03, 32'h00000018, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h06, 32'h00000298, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h0C, 32'h00003A98, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h18, 32'h0004BA98, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h30, 32'h005CBA98, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h60, 32'h06DCBA98, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'hC0, 32'h7EDCBA98, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h80, 32'hFEDCBA98, 0, 1);
        add(0, 0, 0, 0, 32'h0,        8'h00, 32'hFEDCBA98, 0, 1);
        add(1, 1, 0, 0, 32'h76543210, 8'h00, 32'h00000000, 0, 0);
        add(0, 1, 0, 0, 32'hFEDCBA98, 8'h00, 32'h00000000, 0, 0);
        add(0, 0, 1, 1, 32'h0,        8'h00, 32'h00000000, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'hFF, 32'h76543210, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'hFE, 32'hFEDCBA90, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h00, 32'hFEDCBA90, 0, 0);
        add(0, 0, 1, 0, 32'h0,        8'h00, 32'hFEDCBA90, 0, 0);
        add(0, 0, 0, 0, 32'h0,        8'h01, 32'hFEDCBA98, 0, 1);

        do_reset();
        chk("rst.out",   out_w,       '0);
        chk("rst.valid", W'(o_valid), '0);
        chk("rst.full",  W'(o_full),  W'(0));
        chk("rst.ready", W'(o_ready), W'(1));
        chk("rst.empty", W'(o_empty), W'(1));

        foreach (tbl[r]) begin
            if (tbl[r].pre_rst) do_reset();
            wr = tbl[r].wr; rd = tbl[r].rd; mode = tbl[r].mode; in_w = tbl[r].din;
            step();
            chk($sformatf("tbl%0d.valid", r), W'(o_valid), W'(tbl[r].ev));
            chk($sformatf("tbl%0d.out", r),   out_w,       tbl[r].eout);
            chk($sformatf("tbl%0d.full", r),  W'(o_full),  W'(tbl[r].ef));
            chk($sformatf("tbl%0d.empty", r), W'(o_empty), W'(tbl[r].ee));
            check_model($sformatf("tbl%0d", r));
        end

        // Fill to full, drop a ninth write, then drain with skewed reads.
        do_reset();
        for (int k = 0; k < int'(DEPTH); k++) begin
            wr = 1'b1; in_w = 32'(32'h11111111 * (k + 1));
            step();
            check_model("fill");
        end
        chk("full.flag",  W'(o_full),  W'(1));
        chk("full.ready", W'(o_ready), W'(0));
        in_w = 32'hAAAAAAAA;
        step();
        chk("full.drop_flag", W'(o_full), W'(1));
        check_model("drop");
        wr = 1'b0; mode = 1'b0;
        vcnt = 0; seen_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            rd = (k < 8);
            step();
            check_model("drain");
            for (int i = 0; i < int'(COL); i++) begin
                if (o_valid[i]) begin
                    vcnt++;
                    if (out_w[i*BW +: BW] == 4'hA) seen_a = 1'b1;
                end
            end
        end
        chk("drain.count",  W'(vcnt),   W'(64));
        chk("drain.no_9th", W'(seen_a), W'(0));
        chk("drain.empty",  W'(o_empty), W'(1));
`ifdef L0_DROP_CNT_EN
        chk("drain.drop_cnt", W'(o_drop_cnt), W'(1));
`endif

        // Wrap-around with writes and skewed reads on the same edges.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            wr = 1'b1; rd = 1'b1; mode = 1'b0; in_w = $urandom;
            step();
            check_model("wrap");
        end
        wr = 1'b0; rd = 1'b0;
        repeat (20) begin step(); check_model("wrap_drain"); end

        // Underflow on an empty bank, then a mode switch with tokens in flight.
        do_reset();
        rd = 1'b1; mode = 1'b0;
        repeat (3) begin
            step();
            chk("uf.valid", W'(o_valid), '0);
            check_model("uf");
        end
        rd = 1'b0;
        repeat (COL) begin step(); check_model("uf_flush"); end
        chk("uf.empty", W'(o_empty), W'(1));
        wr = 1'b1;
        repeat (4) begin in_w = $urandom; step(); check_model("sw_fill"); end
        wr = 1'b0;
        rd = 1'b1; mode = 1'b0; step(); chk("sw.e0", W'(o_valid), W'(8'h00));
        rd = 1'b1; mode = 1'b1; step(); chk("sw.e1", W'(o_valid), W'(8'h01));
        rd = 1'b0;               step(); chk("sw.e2", W'(o_valid), W'(8'hFF));
        check_model("sw.e2");
        step(); chk("sw.e3", W'(o_valid), W'(8'hFE));
        repeat (10) begin step(); check_model("sw_tail"); end

        // Asynchronous reset asserted between edges in the middle of traffic.
        wr = 1'b1;
        repeat (3) begin in_w = $urandom; step(); end
        wr = 1'b0; rd = 1'b1; mode = 1'b1;
        step();
        rd = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst.out",   out_w,       '0);
        chk("arst.valid", W'(o_valid), '0);
        chk("arst.empty", W'(o_empty), W'(1));
        chk("arst.ready", W'(o_ready), W'(1));
        chk("arst.full",  W'(o_full),  W'(0));
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
        check_model("arst");

        // Randomized traffic: write-heavy then read-heavy.
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 600; n++) begin
                wr   = (ph == 0) ? ($urandom_range(9, 0) < 8) : ($urandom_range(9, 0) < 3);
                rd   = (ph == 0) ? ($urandom_range(9, 0) < 3) : ($urandom_range(9, 0) < 8);
                mode = ($urandom_range(3, 0) == 0);
                in_w = $urandom;
                step();
                check_model("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
